// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built around one full-adder cell and a carry flop.
// Operands are latched on an accepted start and added LSB first, one bit per clock.
// The finished sum and carry-out are published together with a one-cycle done pulse.
//
// Handshake: start is a request that is accepted on a rising edge whenever busy=0
// (IDLE or DONE state); a and b are sampled only on that accepting edge. There is
// no backpressure. done is a one-cycle valid strobe that marks the edge at which
// sum/carry were updated. sum/carry then hold until the next completion or reset.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [1:0]       dbg_state
);

  // Counter holds 0..WIDTH-1 during a run; one spare bit keeps WIDTH=1 legal.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;

  logic             load;
  logic             step;
  logic             finish;
  logic             last_bit;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_n;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s_bit;
  logic             c_n;

  // Counter reaches WIDTH-1 on entry to the final RUN cycle.
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // State register; reset overrides everything including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and control strobes for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here; operands in flight are untouched.
        step = 1'b1;
        if (last_bit) begin
          finish  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        // A start in the DONE cycle is accepted so back-to-back runs lose no cycle.
        if (start) begin
          load    = 1'b1;
          state_n = ST_RUN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Single full-adder cell and the partial result with the new bit entering at the MSB.
  always_comb begin
    s_bit            = op_a[0] ^ op_b[0] ^ c;
    c_n              = (op_a[0] & op_b[0]) | (c & (op_a[0] ^ op_b[0]));
    res_n            = res >> 1;
    res_n[WIDTH-1]   = s_bit;
  end

  // Operand shift registers, carry flop, counter and the partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
      res  <= '0;
      cnt  <= '0;
      c    <= 1'b0;
    end else if (load) begin
      op_a <= a;
      op_b <= b;
      res  <= '0;
      cnt  <= '0;
      c    <= 1'b0;
    end else if (step) begin
      op_a <= op_a >> 1;
      op_b <= op_b >> 1;
      res  <= res_n;
      cnt  <= cnt + CW'(1);
      c    <= c_n;
    end
  end

  // Published result changes only at completion, so partial bits never leak out.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      carry <= 1'b0;
    end else if (finish) begin
      sum   <= res_n;
      carry <= c_n;
    end
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed WIDTH=8 vectors, exhaustive WIDTH=4 and WIDTH=1.
// Drivers push expected {carry,sum} into per-instance queues; monitors pop on done.
module tb_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- WIDTH=8 instance ----------------
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, carry8;
  logic [7:0] sum8;
  logic [1:0] st8;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .dbg_state(st8)
  );

  // ---------------- WIDTH=4 instance ----------------
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4, done4, carry4;
  logic [3:0] sum4;
  logic [1:0] st4;

  serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .dbg_state(st4)
  );

  // ---------------- WIDTH=1 instance ----------------
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1, done1, carry1;
  logic [0:0] sum1;
  logic [1:0] st1;

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .dbg_state(st1)
  );

  // ---------------- scoreboard queues ----------------
  logic [8:0] exp_q8[$];
  logic [4:0] exp_q4[$];
  logic [1:0] exp_q1[$];
  logic [8:0] held8 = '0;
  logic [8:0] e8;
  logic [4:0] e4;
  logic [1:0] e1;
  int         done_cnt8 = 0;

  // Monitor for WIDTH=8: compare on done, and check the held result while busy.
  always @(negedge clk) begin
    if (rst) begin
      held8 = '0;
      exp_q8.delete();
    end else if (done8) begin
      done_cnt8++;
      checks++;
      if (exp_q8.size() == 0) begin
        errors++;
        $display("FAIL w8_unexpected_done: got carry=%b sum=%h, nothing expected", carry8, sum8);
      end else begin
        e8 = exp_q8.pop_front();
        if ({carry8, sum8} !== e8) begin
          errors++;
          $display("FAIL w8_result: got carry=%b sum=%h, expected carry=%b sum=%h",
                   carry8, sum8, e8[8], e8[7:0]);
        end
        held8 = e8;
      end
    end else if (busy8) begin
      checks++;
      if ({carry8, sum8} !== held8) begin
        errors++;
        $display("FAIL w8_hold_during_run: got carry=%b sum=%h, expected carry=%b sum=%h",
                 carry8, sum8, held8[8], held8[7:0]);
      end
    end
  end

  // Monitor for WIDTH=4.
  always @(negedge clk) begin
    if (!rst && done4) begin
      checks++;
      if (exp_q4.size() == 0) begin
        errors++;
        $display("FAIL w4_unexpected_done: got %b_%h", carry4, sum4);
      end else begin
        e4 = exp_q4.pop_front();
        if ({carry4, sum4} !== e4) begin
          errors++;
          $display("FAIL w4_result: got carry=%b sum=%h, expected carry=%b sum=%h",
                   carry4, sum4, e4[4], e4[3:0]);
        end
      end
    end
  end

  // Monitor for WIDTH=1.
  always @(negedge clk) begin
    if (!rst && done1) begin
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL w1_unexpected_done: got %b%b", carry1, sum1);
      end else begin
        e1 = exp_q1.pop_front();
        if ({carry1, sum1} !== e1) begin
          errors++;
          $display("FAIL w1_result: got carry=%b sum=%b, expected carry=%b sum=%b",
                   carry1, sum1, e1[1], e1[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // One WIDTH=8 add; verifies done latency and busy length from the accepting edge.
  task automatic add8(input logic [7:0] ta, input logic [7:0] tb_v, input logic [8:0] texp);
    int n;
    int nb;
    @(posedge clk); #1;
    a8 = ta; b8 = tb_v; start8 = 1'b1;
    exp_q8.push_back(texp);
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom_range(0, 255));
    b8 = 8'($urandom_range(0, 255));
    n = 0; nb = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (busy8) nb++;
      if (done8) break;
    end
    check_val("w8_done_latency", n, 9);
    check_val("w8_busy_cycles", nb, 8);
  endtask

  task automatic add4(input logic [3:0] ta, input logic [3:0] tb_v);
    int n;
    @(posedge clk); #1;
    a4 = ta; b4 = tb_v; start4 = 1'b1;
    exp_q4.push_back({1'b0, ta} + {1'b0, tb_v});
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (done4) break;
    end
    check_val("w4_done_latency", n, 5);
  endtask

  task automatic add1(input logic ta, input logic tb_v, input logic [1:0] texp);
    int n;
    @(posedge clk); #1;
    a1 = ta; b1 = tb_v; start1 = 1'b1;
    exp_q1.push_back(texp);
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (n < 6) begin
      @(negedge clk);
      n++;
      if (done1) break;
    end
    check_val("w1_done_latency", n, 2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    int n;

    // Reset then idle for 20 cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || carry8 !== 1'b0 || st8 !== 2'd0) begin
        errors++;
        $display("FAIL reset_idle: busy=%b done=%b sum=%h carry=%b state=%0d, expected 0 0 00 0 0",
                 busy8, done8, sum8, carry8, st8);
      end
    end

    // Directed WIDTH=8 vectors with hand-computed {carry,sum}.
    add8(8'h0F, 8'h01, 9'h010);
    add8(8'h00, 8'h00, 9'h000);
    add8(8'hFF, 8'h01, 9'h100);
    add8(8'hFF, 8'hFF, 9'h1FE);
    add8(8'h5A, 8'h33, 9'h08D);

    // Start during RUN is ignored, as are operand changes.
    @(posedge clk); #1;
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    exp_q8.push_back(9'h046);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    d0 = done_cnt8;
    repeat (20) @(negedge clk);
    check_val("w8_single_done_when_busy", done_cnt8 - d0, 1);

    // Back-to-back with start held high: one result every 9 cycles.
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    for (int k = 0; k < 3; k++) exp_q8.push_back(9'h100);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (n < 20) begin
        @(negedge clk);
        n++;
        if (done8) break;
      end
      check_val("w8_back_to_back_period", n, 9);
    end
    start8 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in RUN cycle 5 abandons the operation.
    @(posedge clk); #1;
    a8 = 8'h0F; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (sum8 !== 8'h00 || carry8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL w8_reset_abort: sum=%h carry=%b busy=%b done=%b, expected 00 0 0 0",
               sum8, carry8, busy8, done8);
    end
    d0 = done_cnt8;
    repeat (20) @(negedge clk);
    check_val("w8_no_done_after_abort", done_cnt8 - d0, 0);

    // WIDTH=1: sum=a^b, carry=a&b.
    add1(1'b0, 1'b0, 2'b00);
    add1(1'b0, 1'b1, 2'b01);
    add1(1'b1, 1'b0, 2'b01);
    add1(1'b1, 1'b1, 2'b10);

    // WIDTH=4 exhaustive.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        add4(4'(ia), 4'(ib));
      end
    end

    repeat (5) @(negedge clk);
    check_val("w8_pending", exp_q8.size(), 0);
    check_val("w4_pending", exp_q4.size(), 0);
    check_val("w1_pending", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
